// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin arbiter sharing one single-port, word-addressed data
//            memory between port 0 (core LSU) and port 1 (debug/DMA loader).
//            Reads and full-word writes occupy one cycle; byte-enabled
//            partial writes become a two-cycle read-modify-write because the
//            memory only has a whole-word write enable.
// Ports    : clk, rst_n (sync, active-low)
//            rN_req/we/addr/wd/be  : request from port N (held until rN_gnt)
//            rN_gnt                : request accepted this cycle (comb)
//            rN_rvalid/rN_rd       : registered response, one cycle after
//                                    grant (two for a partial write)
//            mem_we/mem_a/mem_wd   : drive the dmem instance
//            mem_rd                : dmem combinational read data
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic [31:0]           r0_addr,
    input  logic [31:0]           r0_wd,
    input  logic [3:0]            r0_be,
    output logic                  r0_gnt,
    output logic                  r0_rvalid,
    output logic [31:0]           r0_rd,
    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic [31:0]           r1_addr,
    input  logic [31:0]           r1_wd,
    input  logic [3:0]            r1_be,
    output logic                  r1_gnt,
    output logic                  r1_rvalid,
    output logic [31:0]           r1_rd,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [31:0]           mem_wd,
    input  logic [31:0]           mem_rd
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } state_t;

    state_t                state_q;
    logic                  last_gnt_q;   // 1 = port 1 was granted most recently
    logic                  port_q;       // owner of the pending RMW write-back
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [31:0]           merge_q;
    logic                  r0_rvalid_q;
    logic                  r1_rvalid_q;
    logic [31:0]           r0_rd_q;
    logic [31:0]           r1_rd_q;

    logic                  w_idle;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_any_gnt;
    logic                  w_we;
    logic [31:0]           w_addr;
    logic [31:0]           w_wd;
    logic [3:0]            w_be;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_full;
    logic                  w_partial;
    logic [31:0]           w_merge;

    // Byte-offset bits and bits above the memory range are deliberately
    // ignored so out-of-range addresses wrap.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{r0_addr[31:ADDR_WIDTH+2], r0_addr[1:0],
                                  r1_addr[31:ADDR_WIDTH+2], r1_addr[1:0]};

    // ------------------------------------------------------------------
    // Arbitration: a lone requester always wins; under contention the
    // port that was not granted last wins. No grants while in reset or
    // while the RMW write-back owns the memory.
    // ------------------------------------------------------------------
    assign w_idle    = (state_q == ST_IDLE);
    assign w_gnt0    = rst_n & w_idle & r0_req & (~r1_req |  last_gnt_q);
    assign w_gnt1    = rst_n & w_idle & r1_req & (~r0_req | ~last_gnt_q);
    assign w_any_gnt = w_gnt0 | w_gnt1;

    assign r0_gnt = w_gnt0;
    assign r1_gnt = w_gnt1;

    // Fields of the granted request
    assign w_we   = w_gnt1 ? r1_we   : r0_we;
    assign w_addr = w_gnt1 ? r1_addr : r0_addr;
    assign w_wd   = w_gnt1 ? r1_wd   : r0_wd;
    assign w_be   = w_gnt1 ? r1_be   : r0_be;
    assign w_idx  = w_addr[ADDR_WIDTH+1:2];

    assign w_full    = w_we & (w_be == 4'hF);
    assign w_partial = w_we & (w_be != 4'h0) & (w_be != 4'hF);

    // Merge new byte lanes over the word currently in memory
    always_comb begin
        w_merge = '0;
        for (int i = 0; i < 4; i++) begin
            w_merge[8*i +: 8] = w_be[i] ? w_wd[8*i +: 8] : mem_rd[8*i +: 8];
        end
    end

    // ------------------------------------------------------------------
    // Memory drive. Address and data are zeroed when unused so the bus
    // is deterministic.
    // ------------------------------------------------------------------
    assign mem_we = rst_n & (((w_any_gnt & w_full)) | (state_q == ST_RMW_WR));

    always_comb begin
        mem_a  = '0;
        mem_wd = '0;
        if (state_q == ST_RMW_WR) begin
            mem_a  = idx_q;
            mem_wd = merge_q;
        end else if (w_any_gnt) begin
            mem_a = w_idx;
            if (w_full) begin
                mem_wd = w_wd;
            end
        end
    end

    // ------------------------------------------------------------------
    // State, arbitration history and registered responses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_gnt_q  <= 1'b1;
            port_q      <= 1'b0;
            idx_q       <= '0;
            merge_q     <= '0;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            r0_rd_q     <= '0;
            r1_rd_q     <= '0;
        end else begin
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_any_gnt) begin
                        last_gnt_q <= w_gnt1;
                        if (w_partial) begin
                            // Ack is deferred until the write-back cycle
                            merge_q <= w_merge;
                            idx_q   <= w_idx;
                            port_q  <= w_gnt1;
                            state_q <= ST_RMW_WR;
                        end else begin
                            if (w_gnt1) begin
                                r1_rvalid_q <= 1'b1;
                            end else begin
                                r0_rvalid_q <= 1'b1;
                            end
                            if (!w_we) begin
                                if (w_gnt1) begin
                                    r1_rd_q <= mem_rd;
                                end else begin
                                    r0_rd_q <= mem_rd;
                                end
                            end
                        end
                    end
                end
                ST_RMW_WR: begin
                    state_q <= ST_IDLE;
                    if (port_q) begin
                        r1_rvalid_q <= 1'b1;
                    end else begin
                        r0_rvalid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign r0_rvalid = r0_rvalid_q;
    assign r1_rvalid = r1_rvalid_q;
    assign r0_rd     = r0_rd_q;
    assign r1_rd     = r1_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench for dmem_arbiter with a behavioural
//            single-port memory attached.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int ADDR_WIDTH = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [31:0] r0_addr, r0_wd, r1_addr, r1_wd;
    logic [3:0]  r0_be, r1_be;
    logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [31:0] r0_rd, r1_rd;
    logic        mem_we;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic [31:0] mem_wd, mem_rd;

    int tests = 0;
    int fails = 0;

    // Behavioural memory: combinational read, clocked whole-word write
    logic [31:0] mem [64] = '{0: 32'h11110000, 4: 32'h44444444, default: 32'h0};
    assign mem_rd = mem[mem_a];
    always @(posedge clk) begin
        if (mem_we) mem[mem_a] <= mem_wd;
    end

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wd(r0_wd),
        .r0_be(r0_be), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rd(r0_rd),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wd(r1_wd),
        .r1_be(r1_be), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rd(r1_rd),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_point();
        @(negedge clk);
    endtask

    task automatic p0(input logic req, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be);
        r0_req = req; r0_we = we; r0_addr = addr; r0_wd = wd; r0_be = be;
    endtask

    task automatic p1(input logic req, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be);
        r1_req = req; r1_we = we; r1_addr = addr; r1_wd = wd; r1_be = be;
    endtask

    initial begin
        int n0, n1;
        logic exp0;
        logic prev_port;

        rst_n = 1'b0;
        p0(1'b1, 1'b1, 32'h0C, 32'hFFFFFFFF, 4'hF);
        p1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Reset: grant and write enable forced low even with a request
        tick();
        tick();
        check_point();
        chk("rst_r0_gnt",    32'(r0_gnt),    32'h0);
        chk("rst_mem_we",    32'(mem_we),    32'h0);
        chk("rst_r0_rvalid", 32'(r0_rvalid), 32'h0);
        chk("rst_r1_rvalid", 32'(r1_rvalid), 32'h0);
        chk("rst_r0_rd",     r0_rd,          32'h0);
        chk("rst_r1_rd",     r1_rd,          32'h0);

        // C1: port 1 full write DEADBEEF to index 3
        tick();
        rst_n = 1'b1;
        p0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        p1(1'b1, 1'b1, 32'h0C, 32'hDEADBEEF, 4'hF);
        check_point();
        chk("c1_r1_gnt",  32'(r1_gnt), 32'h1);
        chk("c1_r0_gnt",  32'(r0_gnt), 32'h0);
        chk("c1_mem_we",  32'(mem_we), 32'h1);
        chk("c1_mem_a",   32'(mem_a),  32'h3);
        chk("c1_mem_wd",  mem_wd,      32'hDEADBEEF);

        // C2: port 0 reads index 3; port 1 write acked
        tick();
        p1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        p0(1'b1, 1'b0, 32'h0C, 32'h0, 4'h0);
        check_point();
        chk("c2_r1_rvalid", 32'(r1_rvalid), 32'h1);
        chk("c2_r0_gnt",    32'(r0_gnt),    32'h1);
        chk("c2_mem_we",    32'(mem_we),    32'h0);
        chk("c2_mem_a",     32'(mem_a),     32'h3);

        // C3: port 0 read response
        tick();
        p0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check_point();
        chk("c3_r0_rvalid", 32'(r0_rvalid), 32'h1);
        chk("c3_r0_rd",     r0_rd,          32'hDEADBEEF);
        chk("c3_r1_rvalid", 32'(r1_rvalid), 32'h0);
        chk("c3_r1_rd",     r1_rd,          32'h0);

        // C4: port 0 partial write, read phase
        tick();
        p0(1'b1, 1'b1, 32'h0C, 32'h00001234, 4'b0011);
        check_point();
        chk("c4_r0_gnt",  32'(r0_gnt), 32'h1);
        chk("c4_mem_we",  32'(mem_we), 32'h0);
        chk("c4_mem_a",   32'(mem_a),  32'h3);

        // C5: write-back phase; port 1 request must wait
        tick();
        p0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        p1(1'b1, 1'b0, 32'h0C, 32'h0, 4'h0);
        check_point();
        chk("c5_mem_we",    32'(mem_we),    32'h1);
        chk("c5_mem_a",     32'(mem_a),     32'h3);
        chk("c5_mem_wd",    mem_wd,         32'hDEAD1234);
        chk("c5_r1_gnt",    32'(r1_gnt),    32'h0);
        chk("c5_r0_rvalid", 32'(r0_rvalid), 32'h0);

        // C6: RMW ack; waiting port 1 read granted
        tick();
        check_point();
        chk("c6_r0_rvalid", 32'(r0_rvalid), 32'h1);
        chk("c6_r1_gnt",    32'(r1_gnt),    32'h1);
        chk("c6_mem_we",    32'(mem_we),    32'h0);

        // C7: port 1 sees merged word
        tick();
        p1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check_point();
        chk("c7_r1_rvalid", 32'(r1_rvalid), 32'h1);
        chk("c7_r1_rd",     r1_rd,          32'hDEAD1234);
        chk("c7_r0_rvalid", 32'(r0_rvalid), 32'h0);

        // C8: be=0 write to wrapping address 0x100 (index 0)
        tick();
        p0(1'b1, 1'b1, 32'h00000100, 32'hFFFFFFFF, 4'h0);
        check_point();
        chk("c8_r0_gnt", 32'(r0_gnt), 32'h1);
        chk("c8_mem_we", 32'(mem_we), 32'h0);

        // C9: ack one cycle later, index 0 untouched, rd unchanged
        tick();
        p0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check_point();
        chk("c9_r0_rvalid", 32'(r0_rvalid), 32'h1);
        chk("c9_mem_we",    32'(mem_we),    32'h0);
        chk("c9_mem0",      mem[0],         32'h11110000);
        chk("c9_r0_rd",     r0_rd,          32'hDEADBEEF);

        // C10: partial write to index 4 (top byte), read phase
        tick();
        p0(1'b1, 1'b1, 32'h10, 32'hAA000000, 4'b1000);
        check_point();
        chk("c10_r0_gnt", 32'(r0_gnt), 32'h1);
        chk("c10_mem_we", 32'(mem_we), 32'h0);

        // C11: reset in the write-back cycle aborts it
        tick();
        p0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst_n = 1'b0;
        check_point();
        chk("c11_mem_we", 32'(mem_we), 32'h0);

        // Contention: both ports read, 4 transactions each, alternating,
        // starting with port 0 since last_gnt was reset
        tick();
        rst_n = 1'b1;
        n0 = 0;
        n1 = 0;
        prev_port = 1'b0;
        for (int k = 0; k < 8; k++) begin
            p0(n0 < 4, 1'b0, 32'h10, 32'h0, 4'h0);
            p1(n1 < 4, 1'b0, 32'h0C, 32'h0, 4'h0);
            check_point();
            exp0 = (k % 2 == 0);
            chk("arb_r0_gnt", 32'(r0_gnt), 32'(exp0));
            chk("arb_r1_gnt", 32'(r1_gnt), 32'(!exp0));
            if (k == 0) begin
                chk("abort_r0_rvalid", 32'(r0_rvalid), 32'h0);
                chk("abort_mem4",      mem[4],         32'h44444444);
                chk("abort_r0_rd",     r0_rd,          32'h0);
                chk("abort_mem_we",    32'(mem_we),    32'h0);
            end else if (prev_port == 1'b0) begin
                chk("arb_r0_rvalid", 32'(r0_rvalid), 32'h1);
                chk("arb_r0_rd",     r0_rd,          32'h44444444);
            end else begin
                chk("arb_r1_rvalid", 32'(r1_rvalid), 32'h1);
                chk("arb_r1_rd",     r1_rd,          32'hDEAD1234);
            end
            if (exp0) n0++; else n1++;
            prev_port = !exp0;
            tick();
        end
        p0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        p1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check_point();
        chk("arb_last_r1_rvalid", 32'(r1_rvalid), 32'h1);
        chk("arb_last_r1_rd",     r1_rd,          32'hDEAD1234);
        chk("arb_idle_r0_gnt",    32'(r0_gnt),    32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, word-addressed data memory between two requesters: port 0 (core load/store unit) and port 1 (debug/DMA loader).
- Performs round-robin arbitration and returns read data / write acks one cycle after grant.
- Implements byte-enabled stores as a two-cycle read-modify-write, because the memory has only a whole-word write enable.
- Sits between the requesters and the dmem instance and drives dmem's we, a and wd directly.

Parameters:
- ADDR_WIDTH, 6, word-index width of the attached memory; must match dmem ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- r0_req  input  1  port 0 request; held high with stable fields until r0_gnt.
- r0_we  input  1  port 0: 1 = write, 0 = read.
- r0_addr  input  32  port 0 byte address.
- r0_wd  input  32  port 0 write data, byte lanes aligned to the word.
- r0_be  input  4  port 0 byte enables (writes only).
- r0_gnt  output  1  port 0 request accepted this cycle.
- r0_rvalid  output  1  port 0 read data / write ack valid, one-cycle pulse.
- r0_rd  output  32  port 0 read data.
- r1_req, r1_we, r1_addr, r1_wd, r1_be, r1_gnt, r1_rvalid, r1_rd: identical set for port 1.
- mem_we  output  1  dmem write enable.
- mem_a  output  ADDR_WIDTH  dmem word index.
- mem_wd  output  32  dmem write data.
- mem_rd  input  32  dmem combinational read data.

Behaviour:
- Word index: addr[ADDR_WIDTH+1:2]. addr[1:0] and bits above ADDR_WIDTH+1 are ignored, so out-of-range addresses wrap silently.
- FSM states:
  - IDLE: arbitrate and issue.
  - RMW_WR: write back the merged word; no grants in this state.
- Arbitration in IDLE:
  - Grant is combinational in the same cycle as req; at most one gnt per cycle.
  - One requester active: that requester is granted.
  - Both active: the port not granted most recently wins.
  - last_gnt register is updated on every grant; it resets to 1, so port 0 wins the first contention.
- Read, granted in cycle N:
  - mem_a = index, mem_we = 0.
  - mem_rd is captured into the port's rd register at the end of cycle N.
  - rvalid = 1 in cycle N+1 only. rd holds its value until the next response to that port.
- Full write (be = 4'hF), granted in cycle N:
  - mem_we = 1 and mem_wd = wd in cycle N.
  - Ack rvalid in N+1; rd is unchanged.
- Partial write (be ∉ {0, F}), granted in cycle N:
  - Cycle N: mem_a = index, mem_we = 0. A merged word is latched: for each byte lane i, be[i] ? wd lane : mem_rd lane. Index and port ID are also latched. Next state is RMW_WR.
  - Cycle N+1: mem_we = 1, mem_a = latched index, mem_wd = merged word. Next state is IDLE.
  - Ack rvalid in N+2. Total occupancy is 2 cycles.
- Write with be = 0: granted, no memory write, ack in N+1.
- Requests arriving during RMW_WR wait. They are arbitrated normally on the return to IDLE, using last_gnt as updated by the RMW grant.
- Back-to-back issue: a new grant is allowed in N+1 after a read or full write, so throughput is one access per cycle.
- Reset (rst_n = 0 at a clock edge):
  - Registers: state = IDLE, last_gnt = 1, r0_rvalid = r1_rvalid = 0, r0_rd = r1_rd = 0, merge/index registers = 0.
  - While rst_n = 0: r0_gnt, r1_gnt and mem_we are forced to 0 combinationally.
  - Reset during RMW_WR aborts the write-back; memory keeps its old word, and no ack is issued.
- mem_a and mem_wd are don't-care when mem_we = 0 and no grant is issued; drive them to 0 for determinism.

Test Plan:
- Reset, then preload index 3 via port 1 full write wd = 32'hDEADBEEF, be = F; port 0 read addr 32'h0C -> r1_gnt same cycle, r1_rvalid next cycle; r0_rvalid one cycle after its grant with r0_rd = 32'hDEADBEEF.
- Port 0 partial write addr 32'h0C, be = 4'b0011, wd = 32'h00001234 -> mem_we = 0 in cycle N, mem_we = 1 with mem_wd = 32'hDEAD1234 in N+1, r0_rvalid in N+2; a subsequent read returns 32'hDEAD1234.
- Both req held for 4 transactions each -> grants alternate 0,1,0,1,...; first contention after reset goes to port 0; never two gnts in one cycle.
- Port 1 req asserted while port 0 RMW is in RMW_WR -> r1_gnt = 0 that cycle, r1_gnt = 1 on the next IDLE cycle; its read returns the merged word.
- Address 32'h0000_0100 (index wraps to 0) with be = 0 write -> ack in N+1, mem_we never asserted, index 0 unchanged.
- rst_n driven low in the RMW_WR cycle -> mem_we = 0, no rvalid, state IDLE after the edge, target word unchanged.
